pe_config_loader: RTL
=====================

// Module: pe_config_loader
// PURPOSE
//   Sending end of the PE configuration interface (PE_inst/init/run).
//   Accepts a host stream of instruction words and writes them, PE-major, into the config buffers of NUM_PE PEs.
//   Each word goes to one PE through a one-hot init strobe on a broadcast PE_inst bus.
//   Then drives a run phase that replays exactly num_ctx contexts in every PE, and reports completion.
// PARAMETERS
//   INST_W  28  width of one PE instruction word (= `PE_inst)
//   DEPTH   16  contexts per PE config buffer (= `buffer_depth)
//   NUM_PE  4   number of PEs served; CW = $clog2(DEPTH+1)
// PORTS
//   clk         in   1             clock, all logic on posedge
//   rst         in   1             synchronous, active-high reset
//   start       in   1             begin a load+run session (sampled in IDLE only)
//   num_ctx     in   CW            contexts per PE for this session, legal 1..DEPTH
//   cfg_valid   in   1             host word valid
//   cfg_ready   out  1             loader accepts word (valid&ready = transfer)
//   cfg_data    in   INST_W        host instruction word
//   pe_rst      out  1             one-cycle clear of PE buffers/counters
//   pe_inst     out  INST_W        broadcast instruction to all PEs
//   pe_init     out  NUM_PE        one-hot write strobe, bit p -> PE p init
//   pe_run      out  1             broadcast run to all PEs
//   busy        out  1             high in any state except IDLE
//   done        out  1             one-cycle pulse at end of run phase
//   err         out  1             one-cycle pulse on rejected start
// BEHAVIOUR
//   Reset: state=IDLE; cfg_ready=0; pe_rst=0; pe_inst=0; pe_init=0; pe_run=0; busy=0; done=0; err=0; counters=0.
//   rst mid-session aborts immediately to IDLE; a partial word transfer is discarded.
//   All outputs are registered.
//   FSM IDLE -> CLR -> LOAD -> DRAIN -> RUN -> FIN -> IDLE:
//   IDLE:  start & 1<=num_ctx<=DEPTH -> latch num_ctx, go CLR.
//          start with num_ctx==0 or >DEPTH -> err=1 next cycle, stay IDLE.
//   CLR:   pe_rst=1 for exactly one cycle; pe_init=0, pe_run=0; clears ctx_cnt, pe_cnt -> LOAD.
//   LOAD:  cfg_ready=1. Each transfer registers pe_inst<=cfg_data, pe_init<=(1<<pe_cnt) for exactly the next cycle.
//          No transfer -> pe_init=0 next cycle; pe_inst holds its last value.
//          ctx_cnt increments per transfer; at ctx_cnt==num_ctx-1 it wraps to 0 and pe_cnt increments.
//          The transfer of word NUM_PE*num_ctx-1 deasserts cfg_ready in the same edge and moves to DRAIN.
//   DRAIN: one cycle, lets the last pe_init write land; cfg_ready=0 -> RUN.
//   RUN:   pe_run=1 for exactly num_ctx consecutive cycles (run_cnt 0..num_ctx-1); pe_init=0 -> FIN.
//          The PE run counter never wraps, so run length never exceeds num_ctx.
//   FIN:   done=1 for one cycle, pe_run=0 -> IDLE. A new session always passes CLR again.
//   cfg_ready is 0 outside LOAD; cfg_valid in other states is ignored (never consumed).
//   start is ignored while busy (no err).
//   At most one pe_init bit is high in any cycle; pe_init, pe_rst and pe_run are mutually exclusive.
//   Word order: word k goes to PE k/num_ctx, context slot k%num_ctx.
//   Latency: transfer at edge t -> PE buffer written at edge t+1.
//   Session cycles with continuous cfg_valid = 1(CLR) + NUM_PE*num_ctx + 1(DRAIN) + num_ctx + 1(FIN).
// TESTING
//   1. num_ctx=2, NUM_PE=4, 8 back-to-back words 0xA0..0xA7 -> pe_init 1,1,2,2,4,4,8,8 with matching pe_inst;
//      then pe_run high 2 cycles; done 1 cycle; total 13 cycles after CLR entry.
//   2. Same, cfg_valid toggled 1/0 each cycle -> pe_init only on transfer+1 cycles, word order preserved, no loss or duplication.
//   3. start with num_ctx=0, then num_ctx=17 -> err pulse each time, busy stays 0, no pe_rst.
//   4. start re-asserted during LOAD, plus cfg_valid during RUN -> ignored; cfg_ready=0 in RUN; single done.
//   5. rst asserted mid-LOAD after 3 words -> next cycle all outputs at reset values;
//      fresh start yields pe_rst pulse, then PE0 written from slot 0.
//   6. num_ctx=DEPTH=16 -> 64 writes, pe_cnt reaches 3 without overflow, pe_run exactly 16 cycles.

Source files
------------

// File: rtl/pe_cfg_if.sv
// Host-side instruction stream into the PE config loader: a valid/ready word channel.
interface pe_cfg_if #(
    parameter int INST_W = 28
) ();
    logic              cfg_valid;
    logic              cfg_ready;
    logic [INST_W-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/pe_config_loader.sv
// Loads a host instruction stream PE-major into NUM_PE config buffers, then runs
// num_ctx contexts in every PE and pulses done.
module pe_config_loader #(
    parameter int INST_W = 28,
    parameter int DEPTH  = 16,
    parameter int NUM_PE = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CW-1:0]     i_num_ctx,
    pe_cfg_if.slave           cfg,
    output logic              o_pe_rst,
    output logic [INST_W-1:0] o_pe_inst,
    output logic [NUM_PE-1:0] o_pe_init,
    output logic              o_pe_run,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_DRAIN, S_RUN, S_FIN} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_num_ctx, w_num_ctx_nxt;
    logic [CW-1:0]     r_ctx_cnt, w_ctx_cnt_nxt;
    logic [CW-1:0]     r_run_cnt, w_run_cnt_nxt;
    logic [PW-1:0]     r_pe_cnt, w_pe_cnt_nxt;
    logic [INST_W-1:0] r_pe_inst, w_pe_inst_nxt;
    logic [NUM_PE-1:0] r_pe_init, w_pe_init_nxt;
    logic              w_err_nxt;
    logic              r_cfg_ready, r_pe_rst, r_pe_run, r_busy, r_done, r_err;
    logic              w_xfer, w_last_ctx, w_last_pe;

    assign w_xfer     = (r_state == S_LOAD) && r_cfg_ready && cfg.cfg_valid;
    assign w_last_ctx = (r_ctx_cnt == r_num_ctx - CW'(1));
    assign w_last_pe  = (r_pe_cnt == PW'(NUM_PE - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_num_ctx_nxt = r_num_ctx;
        w_ctx_cnt_nxt = r_ctx_cnt;
        w_run_cnt_nxt = r_run_cnt;
        w_pe_cnt_nxt  = r_pe_cnt;
        w_pe_inst_nxt = r_pe_inst;
        w_pe_init_nxt = '0;
        w_err_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_num_ctx != '0 && i_num_ctx <= CW'(DEPTH)) begin
                        w_num_ctx_nxt = i_num_ctx;
                        w_state_nxt   = S_CLR;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_CLR: begin
                w_ctx_cnt_nxt = '0;
                w_pe_cnt_nxt  = '0;
                w_state_nxt   = S_LOAD;
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_pe_inst_nxt = cfg.cfg_data;
                    w_pe_init_nxt = NUM_PE'(1) << r_pe_cnt;
                    if (w_last_ctx) begin
                        w_ctx_cnt_nxt = '0;
                        // The final word leaves pe_cnt on the last PE rather than wrapping it.
                        if (w_last_pe) begin
                            w_state_nxt = S_DRAIN;
                        end else begin
                            w_pe_cnt_nxt = r_pe_cnt + PW'(1);
                        end
                    end else begin
                        w_ctx_cnt_nxt = r_ctx_cnt + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                w_run_cnt_nxt = '0;
                w_state_nxt   = S_RUN;
            end
            S_RUN: begin
                if (r_run_cnt == r_num_ctx - CW'(1)) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_run_cnt_nxt = r_run_cnt + CW'(1);
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State-qualified outputs are registered from the state being entered, so they
    // line up exactly with the cycles spent in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num_ctx   <= '0;
            r_ctx_cnt   <= '0;
            r_run_cnt   <= '0;
            r_pe_cnt    <= '0;
            r_pe_inst   <= '0;
            r_pe_init   <= '0;
            r_cfg_ready <= 1'b0;
            r_pe_rst    <= 1'b0;
            r_pe_run    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_num_ctx   <= w_num_ctx_nxt;
            r_ctx_cnt   <= w_ctx_cnt_nxt;
            r_run_cnt   <= w_run_cnt_nxt;
            r_pe_cnt    <= w_pe_cnt_nxt;
            r_pe_inst   <= w_pe_inst_nxt;
            r_pe_init   <= w_pe_init_nxt;
            r_cfg_ready <= (w_state_nxt == S_LOAD);
            r_pe_rst    <= (w_state_nxt == S_CLR);
            r_pe_run    <= (w_state_nxt == S_RUN);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_FIN);
            r_err       <= w_err_nxt;
        end
    end

    assign cfg.cfg_ready = r_cfg_ready;
    assign o_pe_rst      = r_pe_rst;
    assign o_pe_inst     = r_pe_inst;
    assign o_pe_init     = r_pe_init;
    assign o_pe_run      = r_pe_run;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
endmodule
